// File: rtl/line_doubler_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : line_doubler_pkg
//  Purpose  : Shared widths, default sizes and the line-buffer word layout
//             for the 15 kHz -> 31 kHz line doubler.
//  Revision : 1.0  initial release
// ============================================================================
package line_doubler_pkg;

    localparam int RGB_W     = 8;
    localparam int PIX_W     = 3 * RGB_W;
    localparam int DEF_LEN   = 1024;
    localparam int DEF_CNT_W = 12;

    // One stored pixel: display-enable flag on top of packed {r,g,b}.
    typedef struct packed {
        logic             de;
        logic [PIX_W-1:0] rgb;
    } pix_word_t;

endpackage
`default_nettype wire

// File: rtl/line_doubler_buf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : line_doubler_buf
//  Purpose  : Ping-pong line store. Simple dual-port RAM with one write port
//             and one registered read port; address is {bank, pixel}.
//  Revision : 1.0  initial release
// ============================================================================
module line_doubler_buf
    import line_doubler_pkg::*;
#(
    parameter int LEN = DEF_LEN,
    parameter int AW  = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic      clk,
    input  logic      we_i,
    input  logic [AW:0] waddr_i,
    input  pix_word_t wdata_i,
    input  logic      re_i,
    input  logic [AW:0] raddr_i,
    output pix_word_t rdata_o
);

    localparam int DEPTH = 2 ** (AW + 1);

    // Contents survive reset on purpose; readers qualify data with their own
    // valid flag, so stale words are never shown.
    pix_word_t mem_q [0:DEPTH-1];
    pix_word_t rdata_q;

    // Write port: one pixel per input pixel enable.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: registered, loaded only when the output side asks for a pixel.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/line_doubler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : line_doubler
//  Purpose  : Captures each 15 kHz input line into one bank of a ping-pong
//             buffer while replaying the previous line twice from the other
//             bank at double pixel rate. All timing is measured from input.
//  Revision : 1.0  initial release
// ============================================================================
module line_doubler
    import line_doubler_pkg::*;
#(
    parameter int LEN   = DEF_LEN,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [PIX_W-1:0] din,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic             hb_in,
    input  logic             vb_in,
    output logic             ce_out,
    output logic [PIX_W-1:0] dout,
    output logic             hs_out,
    output logic             vs_out,
    output logic             de_out
);

    localparam int               AW      = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W:0]   LEN_X   = (CNT_W + 1)'(LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // ---------------- input side state ----------------
    logic             hs_prev_q;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] line_len_q;
    logic [CNT_W-1:0] hs_w_q;
    logic             wbank_q;
    logic             seen_q;
    logic             valid_q;
    logic             vs_lat_q;
    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] ce_per_q;

    // ---------------- output side state ----------------
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] oc_q, oc_d;
    logic             s1_ce_q, s1_ok_q, s1_hs_q, s1_vs_q;
    logic             ce_out_q, hs_out_q, vs_out_q, de_out_q;
    logic [PIX_W-1:0] dout_q;

    logic             w_line_start, w_hs_fall, w_wbank, w_we, w_run, w_tick;
    logic [CNT_W-1:0] w_pix_idx, w_shr, w_half;
    pix_word_t        w_wdata, w_rdata;

    // The pixel carrying the hs rising edge is index 0 of the new line and is
    // written into the bank being switched to, so line_len is the true count.
    assign w_line_start = ce_pix & hs_in & ~hs_prev_q;
    assign w_hs_fall    = ce_pix & ~hs_in & hs_prev_q;
    assign w_pix_idx    = w_line_start ? '0 : in_cnt_q;
    assign w_wbank      = w_line_start ? ~wbank_q : wbank_q;
    assign w_we         = ce_pix & ({1'b0, w_pix_idx} < LEN_X);
    assign w_wdata      = '{de: ~(hb_in | vb_in), rgb: din};

    // Output pixel rate: half the measured input period, never below one clock.
    assign w_shr  = ce_per_q >> 1;
    assign w_half = (w_shr == '0) ? CNT_ONE : w_shr;
    assign w_run  = (line_len_q != '0);
    assign w_tick = w_run & (div_q >= (w_half - CNT_ONE));

    // Pixel index advance; saturates so an endless line cannot wrap the count.
    always_comb begin
        in_cnt_d = sat_inc(w_pix_idx);
    end

    // Input capture bookkeeping and period measurement.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_prev_q  <= 1'b0;
            in_cnt_q   <= '0;
            line_len_q <= '0;
            hs_w_q     <= '0;
            wbank_q    <= 1'b0;
            seen_q     <= 1'b0;
            valid_q    <= 1'b0;
            vs_lat_q   <= 1'b0;
            per_cnt_q  <= '0;
            ce_per_q   <= '0;
        end else begin
            per_cnt_q <= ce_pix ? '0 : sat_inc(per_cnt_q);
            if (ce_pix) begin
                ce_per_q  <= sat_inc(per_cnt_q);
                hs_prev_q <= hs_in;
                in_cnt_q  <= in_cnt_d;
                if (w_hs_fall) begin
                    hs_w_q <= w_pix_idx;
                end
                // Length is kept unclamped so replay timing tracks the input
                // line; pixels past the buffer depth are shown as blank.
                if (w_line_start) begin
                    line_len_q <= in_cnt_q;
                    wbank_q    <= ~wbank_q;
                    valid_q    <= seen_q;
                    seen_q     <= 1'b1;
                    vs_lat_q   <= vs_in;
                end
            end
        end
    end

    // Divider and replay counter; an input line start overrides the wrap.
    always_comb begin
        div_d = div_q;
        oc_d  = oc_q;
        if (w_tick) begin
            div_d = '0;
            if (({1'b0, oc_q} + (CNT_W + 1)'(1)) >= {1'b0, line_len_q}) begin
                oc_d = '0;
            end else begin
                oc_d = oc_q + CNT_ONE;
            end
        end else if (w_run) begin
            div_d = sat_inc(div_q);
        end
        if (w_line_start) begin
            div_d = '0;
            oc_d  = '0;
        end
    end

    // Output divider and pixel counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            oc_q  <= '0;
        end else begin
            div_q <= div_d;
            oc_q  <= oc_d;
        end
    end

    line_doubler_buf #(
        .LEN (LEN),
        .AW  (AW)
    ) u_buf (
        .clk     (clk),
        .we_i    (w_we),
        .waddr_i ({w_wbank, w_pix_idx[AW-1:0]}),
        .wdata_i (w_wdata),
        .re_i    (w_tick),
        .raddr_i ({~wbank_q, oc_q[AW-1:0]}),
        .rdata_o (w_rdata)
    );

    // Stage 1: side-band decisions travel alongside the RAM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_ce_q <= 1'b0;
            s1_ok_q <= 1'b0;
            s1_hs_q <= 1'b0;
            s1_vs_q <= 1'b0;
        end else begin
            s1_ce_q <= w_tick;
            if (w_tick) begin
                s1_ok_q <= valid_q & ({1'b0, oc_q} < LEN_X);
                s1_hs_q <= (oc_q < hs_w_q);
                if (oc_q == '0) begin
                    s1_vs_q <= vs_lat_q;
                end
            end
        end
    end

    // Stage 2: output register, all outputs change together with ce_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            ce_out_q <= 1'b0;
            dout_q   <= '0;
            hs_out_q <= 1'b0;
            vs_out_q <= 1'b0;
            de_out_q <= 1'b0;
        end else begin
            ce_out_q <= s1_ce_q;
            if (s1_ce_q) begin
                dout_q   <= s1_ok_q ? w_rdata.rgb : '0;
                de_out_q <= s1_ok_q & w_rdata.de;
                hs_out_q <= s1_hs_q;
                vs_out_q <= s1_vs_q;
            end
        end
    end

    assign ce_out = ce_out_q;
    assign dout   = dout_q;
    assign hs_out = hs_out_q;
    assign vs_out = vs_out_q;
    assign de_out = de_out_q;

endmodule
`default_nettype wire

// File: tb/tb_line_doubler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_line_doubler
//  Purpose  : Directed bench for line_doubler. Two instances share stimulus:
//             one with the default depth, one with a 256-pixel buffer so that
//             384- and 300-pixel lines overflow it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_line_doubler;

    localparam int LEN_A = 1024;
    localparam int LEN_B = 256;
    localparam logic [23:0] RED  = 24'hFF0000;
    localparam logic [23:0] BLUE = 24'h0000FF;

    logic        clk = 1'b0;
    logic        reset, ce_pix, hs_in, vs_in, hb_in, vb_in;
    logic [23:0] din;
    logic        ce_a, hs_a, vs_a, de_a;
    logic [23:0] dout_a;
    logic        ce_b, hs_b, vs_b, de_b;
    logic [23:0] dout_b;

    line_doubler #(.LEN(LEN_A), .CNT_W(12)) u_dut_a (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .din(din),
        .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
        .ce_out(ce_a), .dout(dout_a), .hs_out(hs_a), .vs_out(vs_a), .de_out(de_a)
    );

    line_doubler #(.LEN(LEN_B), .CNT_W(12)) u_dut_b (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .din(din),
        .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
        .ce_out(ce_b), .dout(dout_b), .hs_out(hs_b), .vs_out(vs_b), .de_out(de_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          t;
        logic [23:0] d;
        logic        hs;
        logic        de;
        logic        vs;
    } rec_t;

    rec_t qa[$];
    rec_t qb[$];
    rec_t ra, rb;

    // Log every output pixel of both instances with the cycle it appeared in.
    always @(negedge clk) begin
        if (ce_a) begin
            ra.t = cyc; ra.d = dout_a; ra.hs = hs_a; ra.de = de_a; ra.vs = vs_a;
            qa.push_back(ra);
        end
        if (ce_b) begin
            rb.t = cyc; rb.d = dout_b; rb.hs = hs_b; rb.de = de_b; rb.vs = vs_b;
            qb.push_back(rb);
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One input line: per-1 idle clocks then one ce_pix clock per pixel.
    // hs high for pixels 0..31, hblank for pixels 0..63.
    task automatic drive_line(input int npix, input int per, input bit use_col,
                              input logic [23:0] col, input int vs_at, output int ls);
        ls = -1;
        for (int i = 0; i < npix; i++) begin
            repeat (per - 1) begin
                @(posedge clk); #1;
                ce_pix = 1'b0;
            end
            @(posedge clk); #1;
            ce_pix = 1'b1;
            hs_in  = (i < 32);
            hb_in  = (i < 64);
            vb_in  = 1'b0;
            din    = use_col ? col : 24'(i);
            if (i == vs_at) vs_in = 1'b1;
            if (i == 0) ls = cyc;
        end
    endtask

    // Output pixels in [t0,t1) must come every 2 clocks starting at t0 and
    // show pixel k mod npix of the replayed line.
    task automatic check_win(input string tag, input int t0, input int t1, input int npix,
                             input bit use_col, input logic [23:0] col, input logic exp_vs,
                             input int exp_n);
        int ka, kb, idx;
        logic [23:0] px;
        ka = 0;
        kb = 0;
        foreach (qa[i]) begin
            if (qa[i].t >= t0 && qa[i].t < t1) begin
                idx = ka % npix;
                px  = use_col ? col : 24'(idx);
                check_val({tag, "_a"},
                          {32'(qa[i].t - t0), qa[i].d, qa[i].hs, qa[i].de, qa[i].vs},
                          {32'(2 * ka), px, (idx < 32), (idx >= 64), exp_vs});
                ka++;
            end
        end
        foreach (qb[i]) begin
            if (qb[i].t >= t0 && qb[i].t < t1) begin
                idx = kb % npix;
                px  = (idx >= LEN_B) ? 24'd0 : (use_col ? col : 24'(idx));
                check_val({tag, "_b"},
                          {32'(qb[i].t - t0), qb[i].d, qb[i].hs, qb[i].de, qb[i].vs},
                          {32'(2 * kb), px, (idx < 32), (idx >= 64) && (idx < LEN_B), exp_vs});
                kb++;
            end
        end
        check_val({tag, "_cnt_a"}, 64'(ka), 64'(exp_n));
        check_val({tag, "_cnt_b"}, 64'(kb), 64'(exp_n));
    endtask

    int s[1:7];
    int dummy;

    initial begin
        reset  = 1'b1;
        ce_pix = 1'b0;
        hs_in  = 1'b0;
        vs_in  = 1'b0;
        hb_in  = 1'b0;
        vb_in  = 1'b0;
        din    = '0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;

        // Run a few lines so the outputs are active, then reset mid-line.
        for (int k = 0; k < 3; k++) drive_line(384, 4, 1'b0, 24'd0, -1, dummy);
        drive_line(150, 4, 1'b0, 24'd0, -1, dummy);
        @(posedge clk); #1;
        ce_pix = 1'b0;
        reset  = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("rst_a", {ce_a, hs_a, vs_a, de_a, dout_a}, 64'd0);
        check_val("rst_b", {ce_b, hs_b, vs_b, de_b, dout_b}, 64'd0);
        qa.delete();
        qb.delete();
        @(posedge clk); #1;
        reset = 1'b0;

        // Steady doubling; vs rises mid-way through line 5.
        for (int k = 1; k <= 7; k++) begin
            drive_line(384, 4, 1'b0, 24'd0, (k == 5) ? 100 : -1, s[k]);
        end
        check_val("first_out_a", 64'((qa.size() > 0) ? qa[0].t : -1), 64'(s[2] + 4));
        check_val("first_out_b", 64'((qb.size() > 0) ? qb[0].t : -1), 64'(s[2] + 4));
        for (int k = 2; k <= 6; k++) begin
            check_win($sformatf("steady%0d", k), s[k] + 4, s[k + 1] + 4, 384,
                      1'b0, 24'd0, (k >= 6), 768);
        end

        // Bank ping-pong with alternating solid colours.
        for (int k = 1; k <= 5; k++) begin
            drive_line(384, 4, 1'b1, (k % 2 == 1) ? RED : BLUE, -1, s[k]);
        end
        for (int k = 2; k <= 4; k++) begin
            check_win($sformatf("bank%0d", k), s[k] + 4, s[k + 1] + 4, 384,
                      1'b1, ((k - 1) % 2 == 1) ? RED : BLUE, 1'b1, 768);
        end

        // Odd period and 300-pixel lines: third replay cut short by line start.
        for (int k = 1; k <= 4; k++) begin
            drive_line(300, 5, 1'b0, 24'd0, -1, s[k]);
        end
        for (int k = 2; k <= 3; k++) begin
            check_win($sformatf("odd%0d", k), s[k] + 4, s[k + 1] + 4, 300,
                      1'b0, 24'd0, 1'b1, 750);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
